pwm_generator: RTL and testbench

- Single-channel PWM stage directly downstream of the clock divider.
- Consumes the divider's one-clk-wide tick as a count enable. Produces a PWM waveform whose period and duty are programmable.
- period and duty are double-buffered: host writes land in shadow registers and take effect only at a period boundary, so no glitched or partial periods appear on the output.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_shadow_regs.sv | 62 ++++++
 rtl/pwm_generator.sv | 71 +++++++
 tb/tb_pwm_generator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared sizing constants for the clock divider / PWM slice.
//   PWM_WIDTH    : default width of the PWM counter, period and duty registers.
//   CLKDIV_WIDTH : width of the upstream clock divider's prescale counter.
package pwm_pkg;

  localparam int PWM_WIDTH    = 8;
  localparam int CLKDIV_WIDTH = 16;

endpackage

// File: rtl/pwm_shadow_regs.sv
// Double-buffered period/duty register pair for one PWM channel.
// Host writes land in the shadow pair and raise a pending flag; the active
// pair picks them up at the next wrap. While the channel is disabled the
// active pair follows the shadow (or a same-cycle write) on every clock.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   wr                  : write strobe for period_in / duty_in
//   period_in, duty_in  : host values (period minus one, high ticks)
//   enable              : channel run enable
//   wrap                : counter wrap event from the owning channel
//   per_act, duty_act   : active period / duty used by the counter/compare
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             enable,
  input  logic             wrap,
  output logic [WIDTH-1:0] per_act,
  output logic [WIDTH-1:0] duty_act
);

  logic [WIDTH-1:0] per_sh;
  logic [WIDTH-1:0] duty_sh;
  logic             pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_sh   <= '0;
      duty_sh  <= '0;
      per_act  <= '0;
      duty_act <= '0;
      pending  <= 1'b0;
    end else begin
      if (wr) begin
        per_sh  <= period_in;
        duty_sh <= duty_in;
      end
      if (!enable || wrap) begin
        // A write landing on the load cycle bypasses the shadow so the
        // newest values are never lost behind a stale pending copy.
        if (wr) begin
          per_act  <= period_in;
          duty_act <= duty_in;
        end else if (!enable || pending) begin
          per_act  <= per_sh;
          duty_act <= duty_sh;
        end
        pending <= 1'b0;
      end else if (wr) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Single-channel PWM stage driven by the clock divider's tick.
// The counter advances on tick and wraps at the active period; pwm_out is
// the registered compare (cnt < duty_act), so it lags cnt by one clock.
// period_end pulses for one clock after each wrap.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   tick                : one-clk count enable from the clock divider
//   wr                  : shadow register write strobe
//   period_in           : period minus one (period = period_in+1 ticks)
//   duty_in             : high time in ticks
//   enable              : channel run enable
//   pwm_out             : registered PWM waveform
//   period_end          : registered one-clk end-of-period pulse
//   cnt_out             : current counter value
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             wr,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             enable,
  output logic             pwm_out,
  output logic             period_end,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] per_act;
  logic [WIDTH-1:0] duty_act;
  logic             wrap;

  assign wrap    = enable & tick & (cnt == per_act);
  assign cnt_out = cnt;

  pwm_shadow_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .period_in (period_in),
    .duty_in   (duty_in),
    .enable    (enable),
    .wrap      (wrap),
    .per_act   (per_act),
    .duty_act  (duty_act)
  );

  // Counter, compare and period marker: all registered from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt        <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= wrap ? '0 : cnt + WIDTH'(1);
      end
      // duty_act > per_act can never be reached by cnt, giving 100% high.
      pwm_out    <= (cnt < duty_act);
      period_end <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
module tb_pwm_generator;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       wr;
  logic [7:0] period_in;
  logic [7:0] duty_in;
  logic       enable;
  logic       pwm_out;
  logic       period_end;
  logic [7:0] cnt_out;

  int checks;
  int errors;

  bit auto_tick;
  int tick_div;
  int ph;

  pwm_generator #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .wr         (wr),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .cnt_out    (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       tick;
    logic       wr;
    logic [7:0] per;
    logic [7:0] duty;
    logic       exp_pwm;
    logic       exp_pe;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: choose tick, let the edge happen, sample 1 ns later.
  task automatic cyc();
    if (auto_tick) begin
      tick = (tick_div <= 1) ? 1'b1 : (ph == 0);
      ph   = (tick_div <= 1) ? 0 : (ph + 1) % tick_div;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] p, input logic [7:0] d);
    wr = 1'b1; period_in = p; duty_in = d;
    cyc();
    wr = 1'b0;
  endtask

  task automatic wait_pe(input string name, input int budget, output int highs);
    int n;
    n = 0; highs = 0;
    do begin
      cyc();
      n++;
      if (pwm_out) highs++;
    end while (!period_end && n < budget);
    if (!period_end) chk({name, "_timeout"}, n, -1);
  endtask

  task automatic wait_cnt(input string name, input int val, input int budget);
    int n;
    n = 0;
    while (int'(cnt_out) != val && n < budget) begin
      cyc();
      n++;
    end
    if (int'(cnt_out) != val) chk({name, "_timeout"}, int'(cnt_out), val);
  endtask

  task automatic measure(input int n, output int highs, output int pes,
                         output int last_pe, output int prefix_ok, output int max_cnt);
    bit seen_low;
    highs = 0; pes = 0; last_pe = 0; prefix_ok = 1; max_cnt = 0; seen_low = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (pwm_out) begin
        highs++;
        if (seen_low) prefix_ok = 0;
      end else begin
        seen_low = 1;
      end
      if (period_end) pes++;
      if (int'(cnt_out) > max_cnt) max_cnt = int'(cnt_out);
      last_pe = int'(period_end);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int h, p, lp, pk, mc;
    checks = 0; errors = 0;
    auto_tick = 1'b0; tick_div = 1; ph = 0;
    rst_n = 1'b0; tick = 1'b0; wr = 1'b0; period_in = '0; duty_in = '0; enable = 1'b0;

    //               rst en tk wr per duty  pwm pe cnt
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 8'd3, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd9, 8'd3, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd5};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd6};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd7};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd8};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd9};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd2};

    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; enable = tbl[i].en; tick = tbl[i].tick;
      wr = tbl[i].wr; period_in = tbl[i].per; duty_in = tbl[i].duty;
      cyc();
      chk($sformatf("vec%0d_pwm", i), int'(pwm_out), int'(tbl[i].exp_pwm));
      chk($sformatf("vec%0d_pe", i), int'(period_end), int'(tbl[i].exp_pe));
      chk($sformatf("vec%0d_cnt", i), int'(cnt_out), int'(tbl[i].exp_cnt));
    end
    wr = 1'b0;
    auto_tick = 1'b1; tick_div = 1; ph = 0;

    // Basic duty 3 of 10, two periods
    wait_pe("basic_sync", 50, h);
    for (int k = 0; k < 2; k++) begin
      measure(10, h, p, lp, pk, mc);
      chk($sformatf("basic%0d_highs", k), h, 3);
      chk($sformatf("basic%0d_pes", k), p, 1);
      chk($sformatf("basic%0d_last_pe", k), lp, 1);
      chk($sformatf("basic%0d_prefix", k), pk, 1);
    end

    // Double buffering: write at cnt=5 must not affect current period
    wait_cnt("dbuf_cnt5", 5, 20);
    do_write(8'd9, 8'd7);
    wait_pe("dbuf_wrap", 20, h);
    chk("dbuf_cur_highs", h, 0);
    measure(10, h, p, lp, pk, mc);
    chk("dbuf_next_highs", h, 7);
    chk("dbuf_next_last_pe", lp, 1);
    chk("dbuf_next_prefix", pk, 1);

    // Extremes
    do_write(8'd9, 8'd0);
    wait_pe("duty0_wrap", 20, h);
    measure(10, h, p, lp, pk, mc);
    chk("duty0_highs", h, 0);
    chk("duty0_pes", p, 1);
    do_write(8'd9, 8'd10);
    wait_pe("duty100_wrap", 20, h);
    measure(10, h, p, lp, pk, mc);
    chk("duty100_highs", h, 10);
    chk("duty100_pes", p, 1);
    chk("duty100_last_pe", lp, 1);

    // Slow tick, period 0
    tick_div = 4; ph = 0;
    do_write(8'd0, 8'd0);
    wait_pe("per0_wrap", 100, h);
    measure(16, h, p, lp, pk, mc);
    chk("per0_pes", p, 4);
    chk("per0_last_pe", lp, 1);
    chk("per0_max_cnt", mc, 0);

    // Slow tick, period 3 duty 2
    do_write(8'd3, 8'd2);
    wait_pe("slow_wrap", 40, h);
    measure(16, h, p, lp, pk, mc);
    chk("slow_highs", h, 8);
    chk("slow_pes", p, 1);
    chk("slow_last_pe", lp, 1);
    chk("slow_prefix", pk, 1);

    // Write on the exact wrap cycle takes effect immediately
    tick_div = 1; ph = 0;
    wait_cnt("bypass_cnt3", 3, 20);
    do_write(8'd4, 8'd1);
    chk("bypass_wrap_pe", int'(period_end), 1);
    measure(5, h, p, lp, pk, mc);
    chk("bypass_highs", h, 1);
    chk("bypass_pes", p, 1);
    chk("bypass_last_pe", lp, 1);
    chk("bypass_pending", int'(dut.u_regs.pending), 0);

    // Reset on a wrap cycle with 100% duty
    do_write(8'd4, 8'd5);
    wait_pe("rst_wrap", 20, h);
    wait_cnt("rst_cnt4", 4, 10);
    rst_n = 1'b0;
    cyc();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_cnt", int'(cnt_out), 0);
    cyc();
    rst_n = 1'b1;
    measure(8, h, p, lp, pk, mc);
    chk("post_rst_highs", h, 0);
    chk("post_rst_max_cnt", mc, 0);
    chk("post_rst_pes", p, 8);

    // Disable mid-period, tick ignored, full first period on re-enable
    do_write(8'd9, 8'd3);
    wait_pe("en_wrap", 20, h);
    wait_cnt("en_cnt2", 2, 20);
    enable = 1'b0;
    cyc();
    chk("dis_cnt", int'(cnt_out), 0);
    chk("dis_pwm", int'(pwm_out), 0);
    chk("dis_pe", int'(period_end), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("dis_hold%0d_cnt", k), int'(cnt_out), 0);
    end
    enable = 1'b1;
    measure(10, h, p, lp, pk, mc);
    chk("reen_highs", h, 3);
    chk("reen_pes", p, 1);
    chk("reen_last_pe", lp, 1);
    chk("reen_prefix", pk, 1);

    // Reset mid-count
    wait_cnt("rst2_cnt5", 5, 20);
    rst_n = 1'b0;
    cyc();
    chk("rst2_cnt", int'(cnt_out), 0);
    chk("rst2_pwm", int'(pwm_out), 0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
